// File: rtl/ftm_pkg.sv
// Shared definitions for the FTM timestamp unit: default widths, the
// per-clock picosecond step and the capture-channel state encoding.

`ifndef NUM_CLK_PER_US
`define NUM_CLK_PER_US 100
`endif

package ftm_pkg;

    // Returns the picoseconds covered by one clock at the given rate in MHz.
    function automatic int ps_per_clk_calc(input int clk_per_us);
        return 1_000_000 / clk_per_us;
    endfunction

    localparam int NUM_CLK_PER_US  = `NUM_CLK_PER_US;
    localparam int TIME_WIDTH_DEF  = 48;
    localparam int EPOCH_WIDTH_DEF = 8;
    localparam int NUM_CH_DEF      = 2;
    localparam int PS_PER_CLK_DEF  = ps_per_clk_calc(NUM_CLK_PER_US);

    // Capture channel: EMPTY holds nothing new, FULL holds a capture awaiting ack.
    typedef enum logic {
        CH_EMPTY = 1'b0,
        CH_FULL  = 1'b1
    } ch_state_t;

endpackage

// File: rtl/ftm_tsu_if.sv
// Capture bus between the timestamp unit and its event sources/consumers.
// The master side raises events and acknowledges captures; the slave side
// (the timestamp unit) returns the captured time, epoch and status flags.

interface ftm_tsu_if
    import ftm_pkg::*;
#(
    parameter int NUM_CH      = NUM_CH_DEF,
    parameter int TIME_WIDTH  = TIME_WIDTH_DEF,
    parameter int EPOCH_WIDTH = EPOCH_WIDTH_DEF
);

    logic [NUM_CH-1:0]             ev;
    logic [NUM_CH-1:0]             ack;
    logic [NUM_CH*TIME_WIDTH-1:0]  ts_time;
    logic [NUM_CH*EPOCH_WIDTH-1:0] ts_epoch;
    logic [NUM_CH-1:0]             ts_valid;
    logic [NUM_CH-1:0]             ts_overrun;

    modport master (
        output ev,
        output ack,
        input  ts_time,
        input  ts_epoch,
        input  ts_valid,
        input  ts_overrun
    );

    modport slave (
        input  ev,
        input  ack,
        output ts_time,
        output ts_epoch,
        output ts_valid,
        output ts_overrun
    );

endinterface

// File: rtl/ftm_ts_capture.sv
// One timestamp capture channel. An event latches the time and epoch seen
// in the same cycle; the capture is held until acknowledged. Events that
// arrive while a capture is pending are dropped and flagged as overrun.

module ftm_ts_capture
    import ftm_pkg::*;
#(
    parameter int TIME_WIDTH  = TIME_WIDTH_DEF,
    parameter int EPOCH_WIDTH = EPOCH_WIDTH_DEF
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   ev,
    input  logic                   ack,
    input  logic [TIME_WIDTH-1:0]  time_in,
    input  logic [EPOCH_WIDTH-1:0] epoch_in,
    output logic [TIME_WIDTH-1:0]  ts_time,
    output logic [EPOCH_WIDTH-1:0] ts_epoch,
    output logic                   ts_valid,
    output logic                   ts_overrun
);

    ch_state_t state;
    ch_state_t state_next;
    logic      capture;
    logic      overrun_next;

    // State, overrun flag and captured values; capture registers hold
    // their last value when the channel empties.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= CH_EMPTY;
            ts_overrun <= 1'b0;
            ts_time    <= '0;
            ts_epoch   <= '0;
        end else begin
            state      <= state_next;
            ts_overrun <= overrun_next;
            if (capture) begin
                ts_time  <= time_in;
                ts_epoch <= epoch_in;
            end
        end
    end

    // Next state, capture strobe and overrun update.
    always_comb begin
        state_next   = state;
        capture      = 1'b0;
        overrun_next = ts_overrun;
        case (state)
            CH_EMPTY: begin
                // An ack with nothing pending has no effect.
                if (ev) begin
                    capture    = 1'b1;
                    state_next = CH_FULL;
                end
            end
            CH_FULL: begin
                if (ack) begin
                    // Acknowledge frees the slot, so a coincident event is
                    // taken as a fresh capture rather than an overrun.
                    overrun_next = 1'b0;
                    if (ev) begin
                        capture = 1'b1;
                    end else begin
                        state_next = CH_EMPTY;
                    end
                end else if (ev) begin
                    overrun_next = 1'b1;
                end
            end
            default: begin
                state_next = CH_EMPTY;
            end
        endcase
    end

    assign ts_valid = (state == CH_FULL);

endmodule

// File: rtl/ftm_tsu.sv
// FTM timestamp unit: a free-running picosecond time counter with an epoch
// counter that advances on every wrap or software load, plus NUM_CH
// independent capture channels sampling the pre-update time and epoch.

module ftm_tsu
    import ftm_pkg::*;
#(
    parameter int TIME_WIDTH  = TIME_WIDTH_DEF,
    parameter int PS_PER_CLK  = PS_PER_CLK_DEF,
    parameter int NUM_CH      = NUM_CH_DEF,
    parameter int EPOCH_WIDTH = EPOCH_WIDTH_DEF
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   enable,
    input  logic                   load_valid,
    input  logic [TIME_WIDTH-1:0]  load_value,
    output logic [TIME_WIDTH-1:0]  time_now,
    output logic [EPOCH_WIDTH-1:0] epoch,
    output logic                   wrap,
    ftm_tsu_if.slave               cap
);

    // One extra bit on the step so the adder's carry marks a wrap.
    localparam logic [TIME_WIDTH:0] STEP = (TIME_WIDTH + 1)'(PS_PER_CLK);

    logic [TIME_WIDTH:0] sum;

    logic [TIME_WIDTH-1:0]  ch_time     [NUM_CH];
    logic [EPOCH_WIDTH-1:0] ch_epoch    [NUM_CH];
    logic                   ch_valid    [NUM_CH];
    logic                   ch_overrun  [NUM_CH];

    assign sum = {1'b0, time_now} + STEP;

    // Time and epoch counters. A load wins over an increment and never
    // reports a wrap; wrap is a single-cycle pulse following the overflow.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            time_now <= '0;
            epoch    <= '0;
            wrap     <= 1'b0;
        end else if (load_valid) begin
            time_now <= load_value;
            epoch    <= epoch + EPOCH_WIDTH'(1);
            wrap     <= 1'b0;
        end else if (enable) begin
            time_now <= sum[TIME_WIDTH-1:0];
            wrap     <= sum[TIME_WIDTH];
            if (sum[TIME_WIDTH]) begin
                epoch <= epoch + EPOCH_WIDTH'(1);
            end
        end else begin
            wrap <= 1'b0;
        end
    end

    // Every channel sees the same current-cycle time and epoch, so
    // simultaneous events produce identical captures.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        ftm_ts_capture #(
            .TIME_WIDTH  (TIME_WIDTH),
            .EPOCH_WIDTH (EPOCH_WIDTH)
        ) u_capture (
            .clk        (clk),
            .rstn       (rstn),
            .ev         (cap.ev[i]),
            .ack        (cap.ack[i]),
            .time_in    (time_now),
            .epoch_in   (epoch),
            .ts_time    (ch_time[i]),
            .ts_epoch   (ch_epoch[i]),
            .ts_valid   (ch_valid[i]),
            .ts_overrun (ch_overrun[i])
        );
    end

    // Pack per-channel results onto the bus, channel i in slice i.
    always_comb begin
        cap.ts_time    = '0;
        cap.ts_epoch   = '0;
        cap.ts_valid   = '0;
        cap.ts_overrun = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cap.ts_time[i*TIME_WIDTH +: TIME_WIDTH]    = ch_time[i];
            cap.ts_epoch[i*EPOCH_WIDTH +: EPOCH_WIDTH] = ch_epoch[i];
            cap.ts_valid[i]                            = ch_valid[i];
            cap.ts_overrun[i]                          = ch_overrun[i];
        end
    end

endmodule

// File: tb/tb_ftm_tsu.sv
// Bench for ftm_tsu: a directed vector table, a hand-written asynchronous
// reset sequence, then randomized traffic against a behavioural model.

module tb_ftm_tsu;

    localparam int TW = 48;
    localparam int EW = 8;
    localparam int NC = 2;
    localparam int PS = 10000;
    localparam longint unsigned MOD = 64'h1_0000_0000_0000;
    localparam int NROWS = 19;
    localparam int NRAND = 3000;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          enable = 1'b0;
    logic          load_valid = 1'b0;
    logic [TW-1:0] load_value = '0;
    logic [TW-1:0] time_now;
    logic [EW-1:0] epoch;
    logic          wrap;

    int n_checks = 0;
    int n_pass = 0;

    ftm_tsu_if #(.NUM_CH(NC), .TIME_WIDTH(TW), .EPOCH_WIDTH(EW)) bus ();

    ftm_tsu #(
        .TIME_WIDTH  (TW),
        .PS_PER_CLK  (PS),
        .NUM_CH      (NC),
        .EPOCH_WIDTH (EW)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .enable     (enable),
        .load_valid (load_valid),
        .load_value (load_value),
        .time_now   (time_now),
        .epoch      (epoch),
        .wrap       (wrap),
        .cap        (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic           ld;
        logic [TW-1:0]  ldv;
        logic           en;
        logic [NC-1:0]  ev;
        logic [NC-1:0]  ack;
        logic [TW-1:0]  t;
        logic [EW-1:0]  e;
        logic           w;
        logic [NC-1:0]  v;
        logic [NC-1:0]  o;
        logic [TW-1:0]  ts1;
        logic [TW-1:0]  ts0;
        logic [EW-1:0]  te1;
        logic [EW-1:0]  te0;
    } vec_t;

    vec_t tbl [NROWS];

    // Behavioural model state
    longint unsigned m_t;
    int              m_e;
    bit              m_w;
    bit              m_v  [NC];
    bit              m_o  [NC];
    longint unsigned m_ct [NC];
    int              m_ce [NC];

    function automatic vec_t mk(input logic ld, input logic [TW-1:0] ldv, input logic en,
                                input logic [NC-1:0] ev, input logic [NC-1:0] ack,
                                input logic [TW-1:0] t, input logic [EW-1:0] e, input logic w,
                                input logic [NC-1:0] v, input logic [NC-1:0] o,
                                input logic [TW-1:0] ts1, input logic [TW-1:0] ts0,
                                input logic [EW-1:0] te1, input logic [EW-1:0] te0);
        vec_t r;
        r.ld = ld; r.ldv = ldv; r.en = en; r.ev = ev; r.ack = ack;
        r.t = t; r.e = e; r.w = w; r.v = v; r.o = o;
        r.ts1 = ts1; r.ts0 = ts0; r.te1 = te1; r.te0 = te0;
        return r;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [TW-1:0] t, input logic [EW-1:0] e,
                             input logic w, input logic [NC-1:0] v, input logic [NC-1:0] o,
                             input logic [NC*TW-1:0] tst, input logic [NC*EW-1:0] tse);
        check({tag, " time_now"},   time_now,       t);
        check({tag, " epoch"},      epoch,          e);
        check({tag, " wrap"},       wrap,           w);
        check({tag, " ts_valid"},   bus.ts_valid,   v);
        check({tag, " ts_overrun"}, bus.ts_overrun, o);
        check({tag, " ts_time"},    bus.ts_time,    tst);
        check({tag, " ts_epoch"},   bus.ts_epoch,   tse);
    endtask

    // Advances the model by one clock using the rules of the unit:
    // channels sample the pre-update time, then the counter moves.
    task automatic model_step(input logic ld, input logic [TW-1:0] ldv, input logic en,
                              input logic [NC-1:0] ev, input logic [NC-1:0] ack);
        longint unsigned nt;
        for (int i = 0; i < NC; i++) begin
            if (!m_v[i]) begin
                if (ev[i]) begin
                    m_ct[i] = m_t; m_ce[i] = m_e; m_v[i] = 1'b1;
                end
            end else if (ack[i]) begin
                m_o[i] = 1'b0;
                if (ev[i]) begin
                    m_ct[i] = m_t; m_ce[i] = m_e;
                end else begin
                    m_v[i] = 1'b0;
                end
            end else if (ev[i]) begin
                m_o[i] = 1'b1;
            end
        end
        if (ld) begin
            m_t = longint'(ldv);
            m_e = (m_e + 1) % 256;
            m_w = 1'b0;
        end else if (en) begin
            nt  = m_t + PS;
            m_w = (nt >= MOD);
            m_t = nt % MOD;
            if (m_w) m_e = (m_e + 1) % 256;
        end else begin
            m_w = 1'b0;
        end
    endtask

    task automatic model_compare(input int cyc);
        logic [NC*TW-1:0] et;
        logic [NC*EW-1:0] ee;
        logic [NC-1:0]    ev_v;
        logic [NC-1:0]    ev_o;
        logic [63:0]      tmp;
        for (int i = 0; i < NC; i++) begin
            tmp = m_ct[i];
            et[i*TW +: TW] = tmp[TW-1:0];
            ee[i*EW +: EW] = EW'(m_ce[i]);
            ev_v[i] = m_v[i];
            ev_o[i] = m_o[i];
        end
        tmp = m_t;
        check_all($sformatf("rand%0d", cyc), tmp[TW-1:0], EW'(m_e), m_w, ev_v, ev_o, et, ee);
    endtask

    initial begin
        logic [63:0] r64;
        logic        r_ld;
        logic [TW-1:0] r_ldv;
        logic        r_en;
        logic [NC-1:0] r_ev;
        logic [NC-1:0] r_ack;

        bus.ev  = '0;
        bus.ack = '0;

        tbl[0]  = mk(0, 0, 1, 2'b00, 2'b00, 10000,  0, 0, 2'b00, 2'b00, 0, 0, 0, 0);
        tbl[1]  = mk(0, 0, 1, 2'b00, 2'b00, 20000,  0, 0, 2'b00, 2'b00, 0, 0, 0, 0);
        tbl[2]  = mk(0, 0, 1, 2'b00, 2'b00, 30000,  0, 0, 2'b00, 2'b00, 0, 0, 0, 0);
        tbl[3]  = mk(0, 0, 1, 2'b00, 2'b00, 40000,  0, 0, 2'b00, 2'b00, 0, 0, 0, 0);
        tbl[4]  = mk(0, 0, 1, 2'b00, 2'b00, 50000,  0, 0, 2'b00, 2'b00, 0, 0, 0, 0);
        tbl[5]  = mk(0, 0, 1, 2'b01, 2'b00, 60000,  0, 0, 2'b01, 2'b00, 0, 50000, 0, 0);
        tbl[6]  = mk(0, 0, 1, 2'b00, 2'b00, 70000,  0, 0, 2'b01, 2'b00, 0, 50000, 0, 0);
        tbl[7]  = mk(0, 0, 1, 2'b00, 2'b00, 80000,  0, 0, 2'b01, 2'b00, 0, 50000, 0, 0);
        tbl[8]  = mk(0, 0, 1, 2'b01, 2'b00, 90000,  0, 0, 2'b01, 2'b01, 0, 50000, 0, 0);
        tbl[9]  = mk(0, 0, 1, 2'b00, 2'b01, 100000, 0, 0, 2'b00, 2'b00, 0, 50000, 0, 0);
        tbl[10] = mk(0, 0, 1, 2'b10, 2'b00, 110000, 0, 0, 2'b10, 2'b00, 100000, 50000, 0, 0);
        tbl[11] = mk(0, 0, 1, 2'b00, 2'b00, 120000, 0, 0, 2'b10, 2'b00, 100000, 50000, 0, 0);
        tbl[12] = mk(0, 0, 1, 2'b10, 2'b10, 130000, 0, 0, 2'b10, 2'b00, 120000, 50000, 0, 0);
        tbl[13] = mk(0, 0, 0, 2'b00, 2'b00, 130000, 0, 0, 2'b10, 2'b00, 120000, 50000, 0, 0);
        tbl[14] = mk(0, 0, 0, 2'b00, 2'b01, 130000, 0, 0, 2'b10, 2'b00, 120000, 50000, 0, 0);
        tbl[15] = mk(1, 48'hFFFF_FFFF_D8F0, 1, 2'b01, 2'b00,
                     48'hFFFF_FFFF_D8F0, 1, 0, 2'b11, 2'b00, 120000, 130000, 0, 0);
        tbl[16] = mk(0, 0, 1, 2'b00, 2'b11, 0,      2, 1, 2'b00, 2'b00, 120000, 130000, 0, 0);
        tbl[17] = mk(0, 0, 1, 2'b11, 2'b00, 10000,  2, 0, 2'b11, 2'b00, 0, 0, 2, 2);
        tbl[18] = mk(1, 48'h1234_5678_9ABC, 0, 2'b00, 2'b11,
                     48'h1234_5678_9ABC, 3, 0, 2'b00, 2'b00, 0, 0, 2, 2);

        // Reset state, held across one clock edge.
        #12;
        check_all("reset", '0, '0, 1'b0, '0, '0, '0, '0);
        rstn = 1'b1;

        // Directed vector table
        for (int r = 0; r < NROWS; r++) begin
            load_valid = tbl[r].ld;
            load_value = tbl[r].ldv;
            enable     = tbl[r].en;
            bus.ev     = tbl[r].ev;
            bus.ack    = tbl[r].ack;
            step();
            check_all($sformatf("row%0d", r), tbl[r].t, tbl[r].e, tbl[r].w, tbl[r].v, tbl[r].o,
                      {tbl[r].ts1, tbl[r].ts0}, {tbl[r].te1, tbl[r].te0});
        end

        // Fill both channels, then pull reset between clock edges.
        load_valid = 1'b0;
        enable     = 1'b1;
        bus.ev     = 2'b11;
        bus.ack    = 2'b00;
        step();
        check("fill ts_valid", bus.ts_valid, 2'b11);
        check("fill ts_time", bus.ts_time, {48'h1234_5678_9ABC, 48'h1234_5678_9ABC});
        bus.ev = 2'b00;
        #3;
        rstn = 1'b0;
        #1;
        check_all("async_reset", '0, '0, 1'b0, '0, '0, '0, '0);
        #1;
        rstn = 1'b1;
        step();
        check_all("post_reset", 48'd10000, '0, 1'b0, '0, '0, '0, '0);

        // Randomized traffic against the model
        m_t = 64'd10000;
        m_e = 0;
        m_w = 1'b0;
        for (int i = 0; i < NC; i++) begin
            m_v[i] = 1'b0; m_o[i] = 1'b0; m_ct[i] = 0; m_ce[i] = 0;
        end
        for (int c = 0; c < NRAND; c++) begin
            r_ld = ($urandom_range(0, 31) == 0);
            if ($urandom_range(0, 1) == 1) begin
                r_ldv = 48'hFFFF_FFFF_FFFF - TW'($urandom_range(0, 40000));
            end else begin
                r64   = {$urandom, $urandom};
                r_ldv = r64[TW-1:0];
            end
            r_en  = ($urandom_range(0, 7) != 0);
            r_ev  = NC'($urandom_range(0, 3));
            r_ack = NC'($urandom_range(0, 3));
            load_valid = r_ld;
            load_value = r_ldv;
            enable     = r_en;
            bus.ev     = r_ev;
            bus.ack    = r_ack;
            model_step(r_ld, r_ldv, r_en, r_ev, r_ack);
            step();
            model_compare(c);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
